rst_seq_ctrl: RTL

- Reset sequencer directly downstream of the bench/system reset generator.
- Takes the primary reset plus a filtered reset-request input.
- Drives NUM_STAGES active-high reset outputs that all assert together and release in a fixed staggered order, so downstream domains leave reset one after another.
- Reports sequencing progress and completion to the consumer of the resets.

---
 rtl/rst_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts NUM_STAGES resets together on any cause, then
// releases them one by one (bit 0 first) after a hold window, STAGE_GAP apart.
module rst_seq_ctrl #(
    parameter int NUM_STAGES    = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int STAGE_GAP     = 4,
    parameter int FILTER_CYCLES = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                rst_req_i,
    output logic [NUM_STAGES-1:0]               rst_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]     stage_idx_o,
    output logic                                seq_busy_o,
    output logic                                seq_done_o
);

    localparam int SW    = $clog2(NUM_STAGES + 1);
    localparam int MAXHG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW    = $clog2(MAXHG + 1);
    localparam int FW    = $clog2(FILTER_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);
    localparam logic [FW-1:0] FILT_MAX   = FW'(FILTER_CYCLES);
    localparam logic [FW-1:0] FILT_PRE   = FW'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                r_state, w_state_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [FW-1:0]         r_filt, w_filt_nx;
    logic [NUM_STAGES-1:0] r_rst, w_rst_nx;
    logic [SW-1:0]         r_stage, w_stage_nx;
    logic                  r_busy, w_busy_nx;
    logic                  r_done, w_done_nx;
    logic                  w_req_active;
    logic                  w_cause;

    // Request is accepted on the edge its counter reaches FILTER_CYCLES and
    // stays accepted while the input remains high (counter saturated).
    assign w_req_active = rst_req_i && ((r_filt == FILT_PRE) || (r_filt == FILT_MAX));
    assign w_cause      = reset || w_req_active;

    always_comb begin
        w_filt_nx  = r_filt;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rst_nx   = r_rst;
        w_stage_nx = r_stage;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;

        if (reset || !rst_req_i) begin
            w_filt_nx = '0;
        end else if (r_filt != FILT_MAX) begin
            w_filt_nx = r_filt + FW'(1);
        end

        // A cause overrides any release scheduled for the same edge.
        if (w_cause) begin
            w_state_nx = ST_HOLD;
            w_cnt_nx   = '0;
            w_rst_nx   = {NUM_STAGES{1'b1}};
            w_stage_nx = '0;
            w_busy_nx  = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_rst_nx   = r_rst << 1;
                        w_stage_nx = SW'(1);
                        w_cnt_nx   = '0;
                        if (NUM_STAGES == 1) begin
                            w_state_nx = ST_RUN;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        w_rst_nx   = r_rst << 1;
                        w_stage_nx = r_stage + SW'(1);
                        w_cnt_nx   = '0;
                        if (r_stage == STAGE_LAST) begin
                            w_state_nx = ST_RUN;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_filt  <= w_filt_nx;
        r_rst   <= w_rst_nx;
        r_stage <= w_stage_nx;
        r_busy  <= w_busy_nx;
        r_done  <= w_done_nx;
    end

    assign rst_o       = r_rst;
    assign stage_idx_o = r_stage;
    assign seq_busy_o  = r_busy;
    assign seq_done_o  = r_done;

endmodule
